// File: rtl/addsub_seq_ctrl.sv
// Word-serial wide add/subtract sequencer over a single W-bit CLA slice.
// Optional: define ADDSUB_SEQ_SAT_EN for signed saturation on overflow.
module addsub_seq_ctrl #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         M,
  input  logic [W*N-1:0] A,
  input  logic [W*N-1:0] B,
  output logic         ready,
  output logic         done,
  output logic [W*N-1:0] S,
  output logic         C,
  output logic         V
);

  localparam int WN = W * N;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

`ifdef ADDSUB_SEQ_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [WN-1:0] a_q, a_d;
  logic [WN-1:0] b_q, b_d;
  logic [WN-1:0] s_q, s_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          cy_q, cy_d;
  logic          c_q, c_d;
  logic          v_q, v_d;

  int            base;
  logic [W-1:0]  wa, wb, wp, wg, wsum;
  logic [W:0]    wc;
  logic          gen, term, prop;
  logic          last;

  // CLA slice on the current word, carries in lookahead form
  always_comb begin
    base = int'(idx_q) * W;
    wa   = a_q[base +: W];
    wb   = b_q[base +: W];
    wp   = wa ^ wb;
    wg   = wa & wb;
    wc   = '0;
    gen  = 1'b0;
    term = 1'b0;
    prop = 1'b0;
    wc[0] = cy_q;
    for (int i = 0; i < W; i++) begin
      gen = 1'b0;
      for (int j = 0; j <= i; j++) begin
        term = wg[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & wp[k];
        end
        gen = gen | term;
      end
      prop = cy_q;
      for (int k = 0; k <= i; k++) begin
        prop = prop & wp[k];
      end
      wc[i+1] = gen | prop;
    end
    wsum = wc[W-1:0] ^ wp;
  end

  assign last = (idx_q == IW'(N - 1));

  // Next-state: accept, step words LSW first, finalize flags
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    c_d     = c_q;
    v_d     = v_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B ^ {WN{M}};
          cy_d    = M;
          idx_d   = '0;
          s_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[base +: W] = wsum;
        cy_d  = wc[W];
        idx_d = idx_q + 1'b1;
        if (last) begin
          idx_d   = '0;
          c_d     = wc[W];
          v_d     = wc[W] ^ wc[W-1];
          state_d = DONE;
          if (SatEn && v_d) begin
            s_d = a_q[WN-1] ? {1'b1, {(WN-1){1'b0}}}
                            : {1'b0, {(WN-1){1'b1}}};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign S     = s_q;
  assign C     = c_q;
  assign V     = v_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Randomized bench for addsub_seq_ctrl against an arithmetic model.
// Honors ADDSUB_SEQ_SAT_EN the same way as the design.
module tb_addsub_seq_ctrl;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int WN = W * N;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          M     = 1'b0;
  logic [WN-1:0] A     = '0;
  logic [WN-1:0] B     = '0;
  logic          ready, done, C, V;
  logic [WN-1:0] S;

  int checks = 0;
  int errors = 0;

  addsub_seq_ctrl #(.W(W), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .M     (M),
    .A     (A),
    .B     (B),
    .ready (ready),
    .done  (done),
    .S     (S),
    .C     (C),
    .V     (V)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide integer arithmetic
  task automatic model(input logic [WN-1:0] a,
                       input logic [WN-1:0] b,
                       input logic m,
                       output logic [WN-1:0] s,
                       output logic c,
                       output logic v);
    logic [WN-1:0] bb;
    logic [WN:0]   full;
    bb   = m ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{WN{1'b0}}, m};
    s    = full[WN-1:0];
    c    = full[WN];
    v    = (a[WN-1] == bb[WN-1]) && (s[WN-1] != a[WN-1]);
`ifdef ADDSUB_SEQ_SAT_EN
    if (v) s = a[WN-1] ? {1'b1, {(WN-1){1'b0}}}
                       : {1'b0, {(WN-1){1'b1}}};
`endif
  endtask

  task automatic run_op(input logic [WN-1:0] a,
                        input logic [WN-1:0] b,
                        input logic m,
                        input bit noise);
    logic [WN-1:0] es;
    logic          ec, ev;
    model(a, b, m, es, ec, ev);
    @(negedge clk);
    chk("ready_idle", ready, 1);
    A = a; B = b; M = m; start = 1'b1;
    @(posedge clk); #1;
    start = noise;
    if (noise) begin
      A = WN'($urandom); B = WN'($urandom); M = 1'($urandom);
    end
    chk("ready_acc", ready, 0);
    chk("done_acc", done, 0);
    for (int j = 1; j < N; j++) begin
      @(posedge clk); #1;
      chk("ready_run", ready, 0);
      chk("done_run", done, 0);
      if (noise) begin
        A = WN'($urandom); B = WN'($urandom); M = 1'($urandom);
      end
    end
    @(posedge clk); #1;
    chk("done_pulse", done, 1);
    chk("ready_done", ready, 0);
    chk("S", S, es);
    chk("C", C, ec);
    chk("V", V, ev);
    @(posedge clk); #1;
    chk("done_clr", done, 0);
    chk("ready_back", ready, 1);
    chk("S_hold", S, es);
    chk("C_hold", C, ec);
    chk("V_hold", V, ev);
    start = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_S", S, 0);
    chk("rst_C", C, 0);
    chk("rst_V", V, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1);

    // abort at idx=2: C/V were 1 from the previous op
    @(negedge clk);
    A = 16'h1234; B = 16'h1111; M = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("partial_S", S, 16'h0045);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    chk("abort_S", S, 0);
    chk("abort_C", C, 0);
    chk("abort_V", V, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < N + 3; j++) begin
      @(posedge clk); #1;
      chk("no_done", done, 0);
    end

    for (int i = 0; i < 40; i++) begin
      run_op(WN'($urandom), WN'($urandom),
             1'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
